// File: rtl/miner_ctrl_pkg.sv
// Shared types and constants for the miner job controller.
// State encoding, result status codes and bus widths.
package miner_ctrl_pkg;

  localparam int MID_W = 256;
  localparam int D2_W  = 96;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  localparam logic [1:0] STATUS_ERROR     = 2'b00;
  localparam logic [1:0] STATUS_FOUND     = 2'b01;
  localparam logic [1:0] STATUS_EXHAUSTED = 2'b10;
  localparam logic [1:0] STATUS_ABORTED   = 2'b11;

  function automatic logic [31:0] adj_nonce(
    input logic [31:0] nonce,
    input logic [31:0] adj
  );
    return nonce - adj;
  endfunction

endpackage

// File: rtl/miner_job_ctrl_if.sv
// Host-side work and result channels of the miner job controller.
// master = host, slave = controller.
interface miner_job_ctrl_if #(
  parameter int ID_W = 8
) ();
  import miner_ctrl_pkg::*;

  logic             work_valid;
  logic             work_ready;
  logic [MID_W-1:0] work_midstate;
  logic [D2_W-1:0]  work_data2;
  logic [ID_W-1:0]  work_id;

  logic             result_valid;
  logic             result_ready;
  logic [31:0]      result_nonce;
  logic [ID_W-1:0]  result_id;
  logic [1:0]       result_status;

  modport master (
    output work_valid, work_midstate, work_data2, work_id,
    output result_ready,
    input  work_ready,
    input  result_valid, result_nonce, result_id, result_status
  );

  modport slave (
    input  work_valid, work_midstate, work_data2, work_id,
    input  result_ready,
    output work_ready,
    output result_valid, result_nonce, result_id, result_status
  );

endinterface

// File: rtl/miner_job_ctrl_work_slot.sv
// Single-entry pending job buffer between host and controller FSM.
// A take in the same cycle as a load attempt wins.
module work_slot
  import miner_ctrl_pkg::*;
#(
  parameter int ID_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MID_W-1:0] load_midstate,
  input  logic [D2_W-1:0]  load_data2,
  input  logic [ID_W-1:0]  load_id,
  input  logic             take,
  output logic             ready,
  output logic             pend_valid,
  output logic [MID_W-1:0] pend_midstate,
  output logic [D2_W-1:0]  pend_data2,
  output logic [ID_W-1:0]  pend_id
);

  assign ready = !pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid    <= 1'b0;
      pend_midstate <= '0;
      pend_data2    <= '0;
      pend_id       <= '0;
    end else if (take) begin
      pend_valid <= 1'b0;
    end else if (load && !pend_valid) begin
      pend_valid    <= 1'b1;
      pend_midstate <= load_midstate;
      pend_data2    <= load_data2;
      pend_id       <= load_id;
    end
  end

endmodule

// File: rtl/miner_job_ctrl.sv
// Job sequencer between host work channel and one sha256 mining core.
// Launches buffered jobs, watches the core and returns tagged results.
module miner_job_ctrl
  import miner_ctrl_pkg::*;
#(
  parameter int          ID_W      = 8,
  parameter logic [31:0] NONCE_ADJ = 32'd0,
  parameter int          DRAIN     = 4,
  parameter int          BUSY_TO   = 16,
  parameter bit          PREEMPT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  miner_job_ctrl_if.slave  host,
  output logic [MID_W-1:0] midstate,
  output logic [D2_W-1:0]  data2,
  output logic             start_mining,
  input  logic             miner_busy,
  input  logic             got_ticket,
  input  logic [31:0]      golden_nonce
);

  localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TO - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN - 1);

  state_t state;
  state_t state_nxt;

  logic             pend_valid;
  logic [MID_W-1:0] pend_midstate;
  logic [D2_W-1:0]  pend_data2;
  logic [ID_W-1:0]  pend_id;
  logic             take;

  logic [15:0]      cnt;
  logic [MID_W-1:0] cur_midstate;
  logic [D2_W-1:0]  cur_data2;
  logic [ID_W-1:0]  cur_id;

  logic             dec;
  logic [1:0]       dec_status;
  logic [31:0]      dec_nonce;

  logic [31:0]      res_nonce;
  logic [ID_W-1:0]  res_id;
  logic [1:0]       res_status;
  logic             reporting;

  work_slot #(
    .ID_W (ID_W)
  ) u_slot (
    .clk           (clk),
    .rst           (rst),
    .load          (host.work_valid),
    .load_midstate (host.work_midstate),
    .load_data2    (host.work_data2),
    .load_id       (host.work_id),
    .take          (take),
    .ready         (host.work_ready),
    .pend_valid    (pend_valid),
    .pend_midstate (pend_midstate),
    .pend_data2    (pend_data2),
    .pend_id       (pend_id)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take       = 1'b0;
    dec        = 1'b0;
    dec_status = STATUS_ERROR;
    dec_nonce  = '0;
    unique case (state)
      S_IDLE: begin
        if (pend_valid) begin
          take      = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT_BUSY;
      // got_ticket here still belongs to the previous job
      S_WAIT_BUSY: begin
        if (miner_busy) begin
          state_nxt = S_RUN;
        end else if (cnt == BUSY_LAST) begin
          dec        = 1'b1;
          dec_status = STATUS_ERROR;
          state_nxt  = S_REPORT;
        end
      end
      S_RUN: begin
        if (PREEMPT && pend_valid) begin
          dec        = 1'b1;
          dec_status = STATUS_ABORTED;
          state_nxt  = S_REPORT;
        end else if (!miner_busy) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (got_ticket) begin
          dec        = 1'b1;
          dec_status = STATUS_FOUND;
          dec_nonce  = adj_nonce(golden_nonce, NONCE_ADJ);
          state_nxt  = S_REPORT;
        end else if (cnt == DRAIN_LAST) begin
          dec        = 1'b1;
          dec_status = STATUS_EXHAUSTED;
          state_nxt  = S_REPORT;
        end
      end
      S_REPORT: begin
        if (host.result_ready) begin
          if (pend_valid) begin
            take      = 1'b1;
            state_nxt = S_LAUNCH;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_mining = (state == S_LAUNCH);
    reporting    = (state == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_LAUNCH || state == S_RUN) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_midstate <= '0;
      cur_data2    <= '0;
      cur_id       <= '0;
    end else if (take) begin
      cur_midstate <= pend_midstate;
      cur_data2    <= pend_data2;
      cur_id       <= pend_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_nonce  <= '0;
      res_id     <= '0;
      res_status <= '0;
    end else if (dec) begin
      res_nonce  <= dec_nonce;
      res_id     <= cur_id;
      res_status <= dec_status;
    end
  end

  assign midstate           = cur_midstate;
  assign data2              = cur_data2;
  assign host.result_valid  = reporting;
  assign host.result_nonce  = res_nonce;
  assign host.result_id     = res_id;
  assign host.result_status = res_status;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Scoreboard bench for miner_job_ctrl with a behavioural core model.
// Directed jobs push expected results/launches; a monitor checks them.
module tb_miner_job_ctrl;
  import miner_ctrl_pkg::*;

  localparam int          ID_W    = 8;
  localparam int          DRAIN   = 4;
  localparam int          BUSY_TO = 16;
  localparam logic [31:0] ADJ     = 32'd3;
  localparam int          NOLAT   = -1;

  localparam logic [MID_W-1:0] MID_A = {8{32'hA5A5_0001}};
  localparam logic [MID_W-1:0] MID_B = {8{32'h5A5A_0002}};
  localparam logic [MID_W-1:0] MID_C = {8{32'hC3C3_0003}};
  localparam logic [D2_W-1:0]  D2_A  = {3{32'h1111_2222}};
  localparam logic [D2_W-1:0]  D2_B  = {3{32'h3333_4444}};
  localparam logic [D2_W-1:0]  D2_C  = {3{32'h5555_6666}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  miner_job_ctrl_if #(.ID_W(ID_W)) host ();

  logic [MID_W-1:0] midstate;
  logic [D2_W-1:0]  data2;
  logic             start_mining;
  logic             miner_busy   = 1'b0;
  logic             got_ticket   = 1'b0;
  logic [31:0]      golden_nonce = '0;

  miner_job_ctrl #(
    .ID_W      (ID_W),
    .NONCE_ADJ (ADJ),
    .DRAIN     (DRAIN),
    .BUSY_TO   (BUSY_TO),
    .PREEMPT   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (host.slave),
    .midstate     (midstate),
    .data2        (data2),
    .start_mining (start_mining),
    .miner_busy   (miner_busy),
    .got_ticket   (got_ticket),
    .golden_nonce (golden_nonce)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      status;
    logic [31:0]     nonce;
    int              lat;
  } res_t;

  typedef struct {
    logic [MID_W-1:0] mid;
    logic [D2_W-1:0]  d2;
    int               ref_cyc;
    bit               after_hs;
  } lau_t;

  res_t res_q[$];
  lau_t lau_q[$];

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  // core model configuration, latched at each start_mining
  int          cfg_mode = 0;
  int          cfg_run  = 0;
  logic [31:0] cfg_gn   = '0;
  bit          core_kill = 1'b0;
  bit          stale_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: find, 1: exhaust, 2: never busy
  initial begin
    int k;
    int mode;
    int run;
    logic [31:0] gn;
    k = -1;
    mode = 0;
    run = 0;
    gn = '0;
    forever begin
      @(posedge clk);
      #1;
      if (core_kill) begin
        miner_busy   = 1'b0;
        got_ticket   = stale_req;
        golden_nonce = 32'hDEAD_BEEF;
        k = -1;
      end else if (start_mining) begin
        k = 0;
        mode = cfg_mode;
        run = cfg_run;
        gn = cfg_gn;
        if (!stale_req) got_ticket = 1'b0;
      end else if (k >= 0) begin
        k++;
        if (k == 3 && mode != 2) begin
          miner_busy = 1'b1;
          got_ticket = 1'b0;
        end
        if (k == 3 + run && mode != 2) miner_busy = 1'b0;
        if (k == 4 + run) begin
          if (mode == 0) begin
            got_ticket   = 1'b1;
            golden_nonce = gn;
          end
          k = -1;
        end
      end
    end
  end

  initial begin
    bit   prev_start;
    bit   prev_valid;
    int   last_start;
    int   last_hs;
    res_t e;
    lau_t l;
    prev_start = 1'b0;
    prev_valid = 1'b0;
    last_start = 0;
    last_hs = -10;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        prev_start = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (start_mining) begin
          chk("start_single", 256'(prev_start), 256'(0));
          last_start = cyc;
          if (lau_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL launch_unexpected: start_mining at cycle %0d, none required", cyc);
          end else begin
            l = lau_q.pop_front();
            chk("launch_midstate", 256'(midstate), 256'(l.mid));
            chk("launch_data2", 256'(data2), 256'(l.d2));
            chk("launch_cycle", 256'(cyc),
                256'(l.after_hs ? last_hs + 1 : l.ref_cyc + 2));
          end
        end
        if (host.result_valid) begin
          if (res_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL result_unexpected: id %0h at cycle %0d, none required",
                     host.result_id, cyc);
          end else begin
            e = res_q[0];
            chk("result_id", 256'(host.result_id), 256'(e.id));
            chk("result_status", 256'(host.result_status), 256'(e.status));
            chk("result_nonce", 256'(host.result_nonce), 256'(e.nonce));
            if (!prev_valid && e.lat >= 0)
              chk("result_latency", 256'(cyc - last_start), 256'(e.lat));
            if (host.result_ready) begin
              void'(res_q.pop_front());
              last_hs = cyc;
            end
          end
        end
        prev_start = start_mining;
        prev_valid = host.result_valid;
      end
    end
  end

  task automatic push_job(input logic [ID_W-1:0] id,
                          input logic [MID_W-1:0] mid,
                          input logic [D2_W-1:0] d2,
                          input logic [1:0] st,
                          input logic [31:0] nonce,
                          input int lat,
                          input bit after_hs);
    int   n;
    res_t e;
    lau_t l;
    n = 0;
    host.work_valid    = 1'b1;
    host.work_id       = id;
    host.work_midstate = mid;
    host.work_data2    = d2;
    while (!host.work_ready && n < 200) begin
      tick();
      n++;
    end
    if (!host.work_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout: id %0h not accepted, work_ready %0b required 1",
               id, host.work_ready);
      host.work_valid = 1'b0;
      return;
    end
    e = '{id: id, status: st, nonce: nonce, lat: lat};
    res_q.push_back(e);
    l = '{mid: mid, d2: d2, ref_cyc: cyc, after_hs: after_hs};
    lau_q.push_back(l);
    tick();
    host.work_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((res_q.size() != 0 || lau_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (res_q.size() != 0 || lau_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results and %0d launches outstanding, 0 required",
               res_q.size(), lau_q.size());
      res_q.delete();
      lau_q.delete();
    end
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!miner_busy && n < 50) begin
      tick();
      n++;
    end
    if (!miner_busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL busy_timeout: miner_busy %0b required 1", miner_busy);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_midstate"}, 256'(midstate), 256'(0));
    chk({tag, "_data2"}, 256'(data2), 256'(0));
    chk({tag, "_start"}, 256'(start_mining), 256'(0));
    chk({tag, "_result_valid"}, 256'(host.result_valid), 256'(0));
    chk({tag, "_result_nonce"}, 256'(host.result_nonce), 256'(0));
    chk({tag, "_result_id"}, 256'(host.result_id), 256'(0));
    chk({tag, "_result_status"}, 256'(host.result_status), 256'(0));
  endtask

  initial begin
    int n;
    host.work_valid    = 1'b0;
    host.work_midstate = '0;
    host.work_data2    = '0;
    host.work_id       = '0;
    host.result_ready  = 1'b1;
    rst = 1'b1;
    tick(3);
    check_cleared("reset");
    chk("reset_work_ready", 256'(host.work_ready), 256'(1));
    rst = 1'b0;
    tick(2);

    // basic find: 0x1234 - 3
    cfg_mode = 0; cfg_run = 6; cfg_gn = 32'h0000_1234;
    push_job(8'h5A, MID_A, D2_A, STATUS_FOUND, 32'h0000_1231, 11, 1'b0);
    wait_drain();
    tick(2);

    // nonce wrap: 1 - 3
    cfg_mode = 0; cfg_run = 3; cfg_gn = 32'h0000_0001;
    push_job(8'h11, MID_B, D2_B, STATUS_FOUND, 32'hFFFF_FFFE, 8, 1'b0);
    wait_drain();
    tick(2);

    // exhaust: result DRAIN cycles after busy falls
    cfg_mode = 1; cfg_run = 4;
    push_job(8'h22, MID_C, D2_C, STATUS_EXHAUSTED, 32'h0, 12, 1'b0);
    wait_drain();
    tick(2);

    // busy never rises
    cfg_mode = 2; cfg_run = 0;
    push_job(8'h33, MID_A, D2_B, STATUS_ERROR, 32'h0, BUSY_TO + 1, 1'b0);
    wait_drain();
    tick(2);

    // preemption of A by B
    cfg_mode = 1; cfg_run = 100000;
    push_job(8'h01, MID_A, D2_A, STATUS_ABORTED, 32'h0, NOLAT, 1'b0);
    wait_busy();
    tick(2);
    cfg_mode = 1; cfg_run = 5;
    push_job(8'h02, MID_B, D2_B, STATUS_EXHAUSTED, 32'h0, 13, 1'b1);
    wait_drain();
    tick(2);

    // backpressure with second job queued and a third refused
    host.result_ready = 1'b0;
    cfg_mode = 1; cfg_run = 2;
    push_job(8'h44, MID_C, D2_C, STATUS_EXHAUSTED, 32'h0, 10, 1'b0);
    n = 0;
    while (!host.result_valid && n < 60) begin
      tick();
      n++;
    end
    chk("bp_result_valid", 256'(host.result_valid), 256'(1));
    cfg_mode = 0; cfg_run = 2; cfg_gn = 32'h0000_0100;
    push_job(8'h55, MID_B, D2_A, STATUS_FOUND, 32'h0000_00FD, 7, 1'b1);
    host.work_valid    = 1'b1;
    host.work_id       = 8'h99;
    host.work_midstate = MID_C;
    host.work_data2    = D2_C;
    for (int i = 0; i < 3; i++) begin
      chk("bp_work_ready_full", 256'(host.work_ready), 256'(0));
      tick();
    end
    host.work_valid = 1'b0;
    tick(5);
    chk("bp_result_held", 256'(host.result_valid), 256'(1));
    host.result_ready = 1'b1;
    wait_drain();
    tick(2);

    // reset while running, then stale ticket through WAIT_BUSY
    cfg_mode = 1; cfg_run = 100000;
    push_job(8'h66, MID_A, D2_C, STATUS_EXHAUSTED, 32'h0, NOLAT, 1'b0);
    wait_busy();
    tick(2);
    stale_req = 1'b1;
    core_kill = 1'b1;
    rst = 1'b1;
    tick();
    check_cleared("midrun_reset");
    rst = 1'b0;
    res_q.delete();
    lau_q.delete();
    tick();
    core_kill = 1'b0;
    chk("post_reset_work_ready", 256'(host.work_ready), 256'(1));
    chk("stale_ticket_present", 256'(got_ticket), 256'(1));
    cfg_mode = 1; cfg_run = 4;
    push_job(8'h77, MID_C, D2_B, STATUS_EXHAUSTED, 32'h0, 12, 1'b0);
    wait_drain();
    stale_req = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
